// File: rtl/ysyx_bus_pkg.sv
// ysyx_bus_pkg: shared state type and constants for the L1 bus arbiter
package ysyx_bus_pkg;
    typedef enum logic [1:0] {IDLE, RD, WR} arb_state_t;
    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;
    localparam int STRB_W    = 8;
endpackage

// File: rtl/ysyx_rr_picker.sv
// ysyx_rr_picker: combinational round-robin / fixed-priority winner select
module ysyx_rr_picker #(
    parameter int N   = 2,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    input  logic           mode,
    output logic [IDW-1:0] winner,
    output logic           valid
);
    logic [IDW:0] base, idx;
    // scan offsets from farthest to nearest so the requester closest to the start point wins
    always_comb begin
        base   = mode ? {(IDW+1){1'b0}} : {1'b0, ptr};
        idx    = '0;
        winner = '0;
        valid  = |req;
        for (int k = N - 1; k >= 0; k--) begin
            idx = base + (IDW+1)'(k);
            idx = (idx >= (IDW+1)'(N)) ? idx - (IDW+1)'(N) : idx;
            if (req[idx[IDW-1:0]]) winner = idx[IDW-1:0];
        end
    end
endmodule

// File: rtl/ysyx_bus_arb.sv
// ysyx_bus_arb: N-master to 1-slave L1 bus arbiter, one locked transaction at a time
`ifndef YSYX_XLEN
`define YSYX_XLEN 64
`endif
module ysyx_bus_arb import ysyx_bus_pkg::*; #(
    parameter int XLEN     = `YSYX_XLEN,
    parameter int NUM_MST  = 2,
    parameter int IDW      = $clog2(NUM_MST),
    parameter int ARB_MODE = ARB_RR
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_MST-1:0]        m_arvalid,
    input  logic [NUM_MST*XLEN-1:0]   m_araddr,
    input  logic [NUM_MST*STRB_W-1:0] m_rstrb,
    output logic [NUM_MST-1:0]        m_rready,
    output logic [XLEN-1:0]           m_rdata,
    output logic [NUM_MST-1:0]        m_rvalid,
    output logic [NUM_MST-1:0]        m_rlast,
    input  logic [NUM_MST-1:0]        m_awvalid,
    input  logic [NUM_MST*XLEN-1:0]   m_awaddr,
    input  logic [NUM_MST-1:0]        m_wvalid,
    input  logic [NUM_MST*XLEN-1:0]   m_wdata,
    input  logic [NUM_MST*STRB_W-1:0] m_wstrb,
    output logic [NUM_MST-1:0]        m_wready,
    output logic                      s_arvalid,
    output logic [XLEN-1:0]           s_araddr,
    output logic [STRB_W-1:0]         s_rstrb,
    input  logic                      s_rready,
    input  logic [XLEN-1:0]           s_rdata,
    input  logic                      s_rvalid,
    input  logic                      s_rlast,
    output logic                      s_awvalid,
    output logic [XLEN-1:0]           s_awaddr,
    output logic                      s_wvalid,
    output logic [XLEN-1:0]           s_wdata,
    output logic [STRB_W-1:0]         s_wstrb,
    input  logic                      s_wready,
    output logic                      busy,
    output logic [IDW-1:0]            grant_id
);
    arb_state_t state;
    logic [IDW-1:0] rr_ptr, winner, nxt_ptr;
    logic [NUM_MST-1:0] wr_req, req;
    logic win_valid, rd, wr;

    assign wr_req  = m_awvalid & m_wvalid;
    assign req     = m_arvalid | wr_req;
    assign rd      = state == RD;
    assign wr      = state == WR;
    assign busy    = state != IDLE;
    assign nxt_ptr = (grant_id == IDW'(NUM_MST - 1)) ? '0 : grant_id + 1'b1;

    ysyx_rr_picker #(.N(NUM_MST), .IDW(IDW)) u_picker (
        .req    (req),
        .ptr    (rr_ptr),
        .mode   (ARB_MODE == ARB_FIXED),
        .winner (winner),
        .valid  (win_valid)
    );

    // grant latch and burst lock: a winner is only chosen in IDLE and held until its completion beat
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
        end else begin
            case (state)
                IDLE: if (win_valid) begin
                    grant_id <= winner;
                    state    <= wr_req[winner] ? WR : RD;
                end
                RD: if (s_rvalid && s_rlast) begin
                    state  <= IDLE;
                    rr_ptr <= nxt_ptr;
                end
                WR: if (s_wready) begin
                    state  <= IDLE;
                    rr_ptr <= nxt_ptr;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // route the granted master to the slave and the slave responses back to that master only
    always_comb begin
        s_arvalid = rd & m_arvalid[grant_id];
        s_araddr  = rd ? m_araddr[grant_id*XLEN +: XLEN] : '0;
        s_rstrb   = rd ? m_rstrb[grant_id*STRB_W +: STRB_W] : '0;
        s_awvalid = wr & m_awvalid[grant_id];
        s_wvalid  = wr & m_wvalid[grant_id];
        s_awaddr  = wr ? m_awaddr[grant_id*XLEN +: XLEN] : '0;
        s_wdata   = wr ? m_wdata[grant_id*XLEN +: XLEN] : '0;
        s_wstrb   = wr ? m_wstrb[grant_id*STRB_W +: STRB_W] : '0;
        m_rdata   = rd ? s_rdata : '0;
        m_rready  = '0;
        m_rvalid  = '0;
        m_rlast   = '0;
        m_wready  = '0;
        m_rready[grant_id] = rd & s_rready;
        m_rvalid[grant_id] = rd & s_rvalid;
        m_rlast[grant_id]  = rd & s_rvalid & s_rlast;
        m_wready[grant_id] = wr & s_wready;
    end
endmodule

// File: tb/tb_ysyx_bus_arb.sv
// tb_ysyx_bus_arb: directed checks of grant, routing, locking and reset for the L1 bus arbiter
module tb_ysyx_bus_arb;
    localparam int N = 3;
    localparam int XL = 32;

    logic clock = 1'b0, reset = 1'b1;
    logic [N-1:0] m_arvalid = '0, m_awvalid = '0, m_wvalid = '0;
    logic [N*XL-1:0] m_araddr = '0, m_awaddr = '0, m_wdata = '0;
    logic [N*8-1:0] m_rstrb = '0, m_wstrb = '0;
    logic s_rready = 1'b0, s_rvalid = 1'b0, s_rlast = 1'b0, s_wready = 1'b0;
    logic [XL-1:0] s_rdata = '0;

    logic [N-1:0] m_rready, m_rvalid, m_rlast, m_wready;
    logic [XL-1:0] m_rdata, s_araddr, s_awaddr, s_wdata;
    logic [7:0] s_rstrb, s_wstrb;
    logic s_arvalid, s_awvalid, s_wvalid, busy;
    logic [1:0] grant_id;

    logic [N-1:0] b_rready, b_rvalid, b_rlast, b_wready;
    logic [XL-1:0] b_rdata, b_araddr, b_awaddr, b_wdata;
    logic [7:0] b_rstrb, b_wstrb;
    logic b_arvalid, b_awvalid, b_wvalid, b_busy;
    logic [1:0] b_grant;

    int n_vec = 0, n_err = 0;
    logic [31:0] beats [4] = '{32'h11, 32'h22, 32'h33, 32'h44};

    always #5 clock = ~clock;

    ysyx_bus_arb #(.XLEN(XL), .NUM_MST(N), .ARB_MODE(0)) dut (
        .clock(clock), .reset(reset),
        .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_rstrb(m_rstrb), .m_rready(m_rready),
        .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_rlast(m_rlast),
        .m_awvalid(m_awvalid), .m_awaddr(m_awaddr), .m_wvalid(m_wvalid), .m_wdata(m_wdata),
        .m_wstrb(m_wstrb), .m_wready(m_wready),
        .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_rstrb(s_rstrb), .s_rready(s_rready),
        .s_rdata(s_rdata), .s_rvalid(s_rvalid), .s_rlast(s_rlast),
        .s_awvalid(s_awvalid), .s_awaddr(s_awaddr), .s_wvalid(s_wvalid), .s_wdata(s_wdata),
        .s_wstrb(s_wstrb), .s_wready(s_wready), .busy(busy), .grant_id(grant_id)
    );

    ysyx_bus_arb #(.XLEN(XL), .NUM_MST(N), .ARB_MODE(1)) dut_fix (
        .clock(clock), .reset(reset),
        .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_rstrb(m_rstrb), .m_rready(b_rready),
        .m_rdata(b_rdata), .m_rvalid(b_rvalid), .m_rlast(b_rlast),
        .m_awvalid(m_awvalid), .m_awaddr(m_awaddr), .m_wvalid(m_wvalid), .m_wdata(m_wdata),
        .m_wstrb(m_wstrb), .m_wready(b_wready),
        .s_arvalid(b_arvalid), .s_araddr(b_araddr), .s_rstrb(b_rstrb), .s_rready(s_rready),
        .s_rdata(s_rdata), .s_rvalid(s_rvalid), .s_rlast(s_rlast),
        .s_awvalid(b_awvalid), .s_awaddr(b_awaddr), .s_wvalid(b_wvalid), .s_wdata(b_wdata),
        .s_wstrb(b_wstrb), .s_wready(s_wready), .busy(b_busy), .grant_id(b_grant)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        step();
        step();
        reset = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant_id, 0);
        chk("rst_arvalid", s_arvalid, 0);
        chk("rst_awvalid", s_awvalid, 0);
        chk("rst_mhs", {m_rready, m_rvalid, m_rlast, m_wready}, 0);
        chk("rst_addr", {s_araddr, s_awaddr, s_wdata}, 0);
        chk("rst_fix_busy", b_busy, 0);

        m_arvalid = 3'b010;
        m_araddr[1*XL +: XL] = 32'h8000_0010;
        m_rstrb[1*8 +: 8] = 8'hFF;
        s_rready = 1'b1;
        #1;
        chk("lat_no_fwd", s_arvalid, 0);
        step();
        chk("rd1_arvalid", s_arvalid, 1);
        chk("rd1_araddr", s_araddr, 32'h8000_0010);
        chk("rd1_rstrb", s_rstrb, 8'hFF);
        chk("rd1_grant", grant_id, 1);
        chk("rd1_busy", busy, 1);
        chk("rd1_rready", m_rready, 3'b010);

        for (int k = 0; k < 4; k++) begin
            s_rvalid = 1'b1;
            s_rdata = beats[k];
            s_rlast = (k == 3);
            if (k == 3) m_arvalid = '0;
            #1;
            chk("burst_rvalid", m_rvalid, 3'b010);
            chk("burst_rlast", m_rlast, (k == 3) ? 3'b010 : 3'b000);
            chk("burst_rdata", m_rdata, beats[k]);
            step();
        end
        s_rvalid = 1'b0;
        s_rlast = 1'b0;
        #1;
        chk("burst_idle", busy, 0);
        chk("burst_hold_grant", grant_id, 1);

        reset = 1'b1;
        step();
        reset = 1'b0;
        m_arvalid = 3'b111;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("rr_order", grant_id, i % 3);
            chk("fix_order", b_grant, 0);
            chk("rr_rvalid_route", m_rvalid, 0);
            s_rvalid = 1'b1;
            s_rlast = 1'b1;
            step();
            s_rvalid = 1'b0;
            s_rlast = 1'b0;
            if (i == 5) m_arvalid = '0;
        end

        m_arvalid = 3'b010;
        m_awvalid = 3'b010;
        m_wvalid = 3'b010;
        m_awaddr[1*XL +: XL] = 32'h100;
        m_wdata[1*XL +: XL] = 32'hDEAD_BEEF;
        m_wstrb[1*8 +: 8] = 8'h0F;
        step();
        chk("wr_awvalid", s_awvalid, 1);
        chk("wr_wvalid", s_wvalid, 1);
        chk("wr_awaddr", s_awaddr, 32'h100);
        chk("wr_wdata", s_wdata, 32'hDEAD_BEEF);
        chk("wr_wstrb", s_wstrb, 8'h0F);
        chk("wr_no_ar", s_arvalid, 0);
        chk("wr_grant", grant_id, 1);
        s_wready = 1'b1;
        #1;
        chk("wr_wready", m_wready, 3'b010);
        m_awvalid = '0;
        m_wvalid = '0;
        step();
        s_wready = 1'b0;
        #1;
        chk("wr_done_idle", busy, 0);
        chk("wr_wready_pulse", m_wready, 0);
        step();
        chk("wr_then_rd", s_arvalid, 1);
        chk("wr_then_rd_grant", grant_id, 1);
        s_rvalid = 1'b1;
        s_rlast = 1'b1;
        #1;
        chk("single_beat_rlast", m_rlast, 3'b010);
        m_arvalid = '0;
        step();
        s_rvalid = 1'b0;
        s_rlast = 1'b0;
        #1;
        chk("single_beat_done", busy, 0);

        m_arvalid = 3'b100;
        m_araddr[2*XL +: XL] = 32'h8000_2000;
        step();
        chk("rst8_grant", grant_id, 2);
        s_rvalid = 1'b1;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        m_arvalid = '0;
        #1;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_grant", grant_id, 0);
        chk("rst_mid_rvalid", m_rvalid, 0);
        chk("rst_mid_arvalid", s_arvalid, 0);
        step();
        chk("trail_rvalid", m_rvalid, 0);
        chk("trail_busy", busy, 0);
        s_rvalid = 1'b0;
        m_arvalid = 3'b110;
        step();
        chk("ptr_restart", grant_id, 1);
        chk("ptr_restart_addr", s_araddr, 32'h8000_0010);
        s_rvalid = 1'b1;
        s_rlast = 1'b1;
        m_arvalid = '0;
        step();
        s_rvalid = 1'b0;
        s_rlast = 1'b0;

        m_arvalid = 3'b001;
        step();
        chk("lock_grant0", grant_id, 0);
        m_arvalid = 3'b100;
        #1;
        chk("lock_drop_ar", s_arvalid, 0);
        chk("lock_busy", busy, 1);
        step();
        chk("lock_hold", grant_id, 0);
        chk("lock_hold_busy", busy, 1);
        s_rvalid = 1'b1;
        s_rlast = 1'b1;
        #1;
        chk("lock_rvalid", m_rvalid, 3'b001);
        chk("lock_rlast", m_rlast, 3'b001);
        step();
        s_rvalid = 1'b0;
        s_rlast = 1'b0;
        #1;
        chk("lock_release", busy, 0);
        step();
        chk("lock_next_grant", grant_id, 2);
        chk("lock_next_ar", s_arvalid, 1);
        chk("lock_next_addr", s_araddr, 32'h8000_2000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ysyx_bus_arb.md
Name: ysyx_bus_arb

Overview:
- N-master to 1-slave arbiter for the L1 cache bus protocol: arvalid/araddr/rstrb/rready/rdata/rvalid/rlast for reads; awvalid/awaddr/wvalid/wdata/wstrb/wready for writes.
- Replaces point-to-point wiring of the l1i and l1d buses with a parametrised, channel-count-generic mux in front of the memory/AXI bridge.
- Holds one transaction at a time, locked until its burst completes, with round-robin or fixed-priority arbitration.

Parameters:
- XLEN, `YSYX_XLEN, address/data width.
- NUM_MST, 2, number of masters; 2..8. Index 0 is l1i, 1 is l1d by convention.
- IDW, $clog2(NUM_MST), grant index width.
- ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- m_arvalid  in  NUM_MST  per-master read request.
- m_araddr  in  NUM_MST*XLEN  read address, master i at [i*XLEN +: XLEN].
- m_rstrb  in  NUM_MST*8  read byte strobe.
- m_rready  out  NUM_MST  slave ready, routed to granted reader only.
- m_rdata  out  XLEN  read data, shared by all masters; valid only with own m_rvalid bit.
- m_rvalid  out  NUM_MST  read beat valid, granted master only.
- m_rlast  out  NUM_MST  last beat, granted master only.
- m_awvalid, m_wvalid  in  NUM_MST each  write address/data valid.
- m_awaddr, m_wdata  in  NUM_MST*XLEN each  write address/data.
- m_wstrb  in  NUM_MST*8  write strobe.
- m_wready  out  NUM_MST  write done, granted master only.
- s_arvalid, s_araddr, s_rstrb, s_rready, s_rdata, s_rvalid, s_rlast  slave-side mirror of the read group; directions reversed, single channel.
- s_awvalid, s_awaddr, s_wvalid, s_wdata, s_wstrb, s_wready  slave-side mirror of the write group; single channel.
- busy  out  1  a transaction is granted.
- grant_id  out  IDW  index of the current or last granted master.

Behaviour:
- States: IDLE, RD, WR, held in a registered enum.
- Reset: state = IDLE, rr_ptr = 0, grant_id = 0.
- Reset clears every output: all s_* valids 0, all m_* handshakes 0, addr/data/strb 0, busy 0.
- Reset mid-burst aborts silently; any remaining slave beats arriving in IDLE are dropped.
- Request per master: req[i] = m_arvalid[i] | (m_awvalid[i] & m_wvalid[i]).
- IDLE:
  - If any req is set, the winner is latched into grant_id.
  - The state moves to WR if the winner has a write pending, otherwise to RD.
  - Writes take precedence over reads within the same master, preserving its store order.
- Arbitration latency is 1 cycle: no forwarding happens in IDLE.
  - Request in cycle t → s_arvalid or s_awvalid asserted in cycle t+1.
- Winner selection:
  - RR: the first requesting index at or after rr_ptr, searching modulo NUM_MST.
  - Fixed: the lowest requesting index.
- RD:
  - Granted master's arvalid/araddr/rstrb drive the slave side.
  - s_rready, s_rvalid and s_rlast are routed only to bit grant_id; all other m_* bits stay 0.
  - s_rdata is passed through unchanged.
  - On s_rvalid & s_rlast: state goes to IDLE and rr_ptr = grant_id+1, wrapping to 0 at NUM_MST.
- WR:
  - Granted master's aw/w signals drive the slave side.
  - On s_wready: m_wready[grant_id] pulses for 1 cycle, then IDLE with rr_ptr advanced as in RD.
- Locking: the grant is never switched mid-transaction.
  - If the granted master drops its valid before completion, the slave valid drops with it, but the grant is held until completion.
- busy = (state != IDLE).
- grant_id holds its value in IDLE for debug and perf.
- Boundary: a single-beat read (rvalid & rlast in the same cycle as the first beat) completes in that cycle.
- Back-to-back requests: the minimum gap between a completion and the next grant's slave valid is 1 cycle.
- Throughput: at most one transaction per 2 cycles plus slave latency.
- A master requesting every cycle in RR mode cannot starve others: worst-case wait is NUM_MST-1 transactions.

Decomposition:
- ysyx_bus_pkg holds:
  - the state typedef (IDLE/RD/WR);
  - the ARB_RR/ARB_FIXED localparams;
  - the strobe width constant of 8.
- Sub-module ysyx_rr_picker: purely combinational.
  - Inputs: req vector, rr_ptr, mode.
  - Outputs: winner index and valid.
  - Reusable by a future L2 arbiter.

Test Plan:
- Idle after reset: all outputs 0. Assert m_arvalid[1] with araddr 0x8000_0010 → s_arvalid=1 and s_araddr=0x8000_0010 one cycle later, grant_id=1, busy=1.
- Burst read, 4 beats: slave returns 0x11,0x22,0x33,0x44 with rlast on beat 4 → m_rvalid[1] pulses 4×, m_rlast[1] on beat 4 only, m_rvalid[0] stays 0, IDLE the next cycle.
- RR fairness (NUM_MST=3): all masters request continuously with single-beat reads → grant order 0,1,2,0,1,2. With ARB_MODE=1 → 0,0,0.
- Same-master read+write: master 1 asserts arvalid plus awvalid/wvalid (addr 0x100, wdata 0xDEAD_BEEF, wstrb 0x0F) → WR first, m_wready[1] pulses, then RD is granted.
- Reset asserted during the third beat of an 8-beat burst → the next cycle is IDLE with all outputs 0. Trailing s_rvalid beats produce no m_rvalid. A new request is granted normally, and rr_ptr restarts from 0.
- Granted master drops arvalid mid-RD → s_arvalid=0, grant_id unchanged, and a competing requester is not granted until s_rlast.
